seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring integer divider, one quotient bit per clock; parametrised-width successor to the 8-bit unsigned divider.
//  Start/ready/done handshake, latched operands, divide-by-zero flag, compile-time optional signed mode.
//  Serves sequencer/ALU paths that need DIV/MOD and can tolerate a fixed multi-cycle latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high
//  start       in   1      request; accepted only in a cycle where ready=1
//  sgn         in   1      1 = signed op (honoured only with DIV_SIGNED_EN); sampled with start
//  dividend    in   WIDTH  numerator, sampled with start
//  divisor     in   WIDTH  denominator, sampled with start
//  ready       out  1      1 in IDLE and DONE states
//  done        out  1      one-cycle pulse: quotient/remainder/div_by_zero valid
//  quotient    out  WIDTH  result, held from done until next accepted start
//  remainder   out  WIDTH  result, held likewise
//  div_by_zero out  1      set with done when divisor==0; held with results
// BEHAVIOUR
//  - Reset (async): state=IDLE; ready=1; done=0; quotient=remainder=0; div_by_zero=0; counter=0.
//  - States: IDLE -> RUN -> (FIXUP) -> DONE. DONE -> IDLE after 1 cycle, or -> RUN directly on start.
//  - Accept: start=1 while ready=1 latches dividend/divisor/sgn; inputs ignored thereafter until next accept.
//  - start while ready=0: ignored, no queueing, no side effects.
//  - RUN: count = WIDTH-1 down to 0; partial rem P is WIDTH+1 bits; Q shift reg initialised to |dividend|.
//    trial = {P[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, |divisor|}.
//    trial[WIDTH]==0: P<=trial, Q<={Q[WIDTH-2:0],1}; else P<={P[WIDTH-1:0],Q[WIDTH-1]}, Q<={Q[WIDTH-2:0],0}.
//  - Exactly WIDTH RUN cycles (count reaching 0 ends RUN); no early termination.
//  - Latency unsigned: start sampled at edge N -> done=1 in the cycle after edge N+WIDTH.
//  - Quotient/remainder outputs update only at the edge that raises done; stale during RUN.
//  - divisor==0 at accept: skip RUN; done next cycle; quotient=all ones, remainder=dividend, div_by_zero=1.
//  - div_by_zero clears on the next accepted start.
//  - dividend==0, divisor!=0: normal path, full latency, q=0 r=0.
//  - Back-to-back: start in the DONE cycle is accepted; zero idle cycles between ops.
//  - reset mid-operation: abort immediately to reset values; no done pulse for aborted op.
// CONFIGURATION
//  DIV_SIGNED_EN defined:
//   - sgn=1: operands two's complement; magnitudes fed to core; extra FIXUP cycle (latency WIDTH+2 from start edge).
//   - Quotient truncates toward zero; remainder takes sign of dividend; q = -(2^(W-1)) r=0 for MIN/-1 (wraps, no flag).
//   - sgn=0: unsigned, no FIXUP, latency as above.
//  DIV_SIGNED_EN undefined:
//   - sgn ignored; all ops unsigned; FIXUP state and sign logic absent.
// TESTING (WIDTH=8 unless noted)
//  - 7/2 unsigned, start at edge 0 -> done pulses in the cycle after edge 8, q=3 r=1, dbz=0, ready=1.
//  - 255/1 then start in DONE cycle with 200/7 -> q=255 r=0, then q=28 r=4; no idle cycle between.
//  - 5/0 -> done cycle after accept, q=8'hFF r=5 dbz=1; next 9/3 -> dbz=0, q=3 r=0.
//  - start pulsed at edge 3 of 100/10 with operands changed -> ignored; result q=10 r=0.
//  - reset asserted mid-RUN of 100/10 -> all outputs 0, ready=1; no done; next 9/4 -> q=2 r=1.
//  - DIV_SIGNED_EN, sgn=1: -7/2 -> q=-3 r=-1 at WIDTH+2; -128/-1 -> q=-128 r=0; WIDTH=16 65535/256 unsigned -> q=255 r=255.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider, one quotient bit per clock.
// Start/ready/done handshake with latched operands and a divide-by-zero flag.
// Optional signed mode is compiled in when DIV_SIGNED_EN is defined; otherwise
// the sgn input is ignored and every operation is unsigned.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] q_nxt;

`ifdef DIV_SIGNED_EN
    logic signed_op;
    logic neg_q;
    logic neg_r;
    logic sg;
    logic unused_bits;
    assign sg          = sgn;
    assign unused_bits = p[WIDTH];
`else
    logic unused_bits;
    assign unused_bits = ^{sgn, p[WIDTH]};
`endif

    // Magnitude of an operand; only negates when the operation is signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {p[WIDTH-1:0], q_sh[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        p_nxt   = trial[WIDTH] ? shifted : trial;
        q_nxt   = {q_sh[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            p           <= '0;
            q_sh        <= '0;
            dvs         <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            signed_op   <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            ready       <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            p           <= '0;
                            count       <= CW'(WIDTH - 1);
                            ready       <= 1'b0;
                            state       <= RUN;
`ifdef DIV_SIGNED_EN
                            q_sh      <= mag(dividend, sg);
                            dvs       <= mag(divisor, sg);
                            signed_op <= sg;
                            neg_q     <= sg & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r     <= sg & dividend[WIDTH-1];
`else
                            q_sh      <= mag(dividend, 1'b0);
                            dvs       <= mag(divisor, 1'b0);
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p    <= p_nxt;
                    q_sh <= q_nxt;
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
`ifdef DIV_SIGNED_EN
                        if (signed_op) begin
                            state <= FIXUP;
                        end else begin
                            quotient  <= q_nxt;
                            remainder <= p_nxt[WIDTH-1:0];
                            done      <= 1'b1;
                            ready     <= 1'b1;
                            state     <= DONE;
                        end
`else
                        quotient  <= q_nxt;
                        remainder <= p_nxt[WIDTH-1:0];
                        done      <= 1'b1;
                        ready     <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    quotient  <= neg_q ? -q_sh : q_sh;
                    remainder <= neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
                    done      <= 1'b1;
                    ready     <= 1'b1;
                    state     <= DONE;
                end
`endif
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
